// File: rtl/digit_pkg.sv
// Shared digit-path definitions for the binary-to-BCD converter and the
// digit renderers downstream of it.
package digit_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic {
      IDLE,
      CONVERT
   } bcd_state_t;

   localparam logic [DIGIT_W-1:0] BLANK_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
   import digit_pkg::*;
(
   input  logic [DIGIT_W-1:0] nibble_i,
   output logic [DIGIT_W-1:0] nibble_o
);

   always_comb begin
      nibble_o = nibble_i;
      if (nibble_i >= DIGIT_W'(5)) begin
         nibble_o = nibble_i + DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter. Result digits are held
// in dedicated output registers so renderers never see partial conversions.
module score_bcd_converter
   import digit_pkg::*;
#(
   parameter int BIN_W      = 10,
   parameter int NUM_DIGITS = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_start,
   input  logic [BIN_W-1:0]                i_value,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [DIGIT_W*NUM_DIGITS-1:0]   o_digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0] o_num_digits,
   output logic                            o_ovf
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ND_W  = $clog2(NUM_DIGITS + 1);
   localparam int OUT_W = DIGIT_W * NUM_DIGITS;
   localparam int BCD_W = DIGIT_W * (NUM_DIGITS + 1);
   localparam int SR_W  = BCD_W + BIN_W;
   localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

   bcd_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic             ovf_work_q, ovf_work_d;
   logic [OUT_W-1:0] digits_q, digits_d;
   logic [ND_W-1:0]  nd_q, nd_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [BCD_W-1:0] adj_bcd;
   logic [SR_W-1:0]  step_next;
   logic [OUT_W-1:0] wb_digits;
   logic [ND_W-1:0]  wb_nd;

   // One correction cell per BCD nibble, including the headroom nibble.
   for (genvar g = 0; g < NUM_DIGITS + 1; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble_i (sr_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
         .nibble_o (adj_bcd[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign step_next = {adj_bcd, sr_q[BIN_W-1:0]} << 1;

   always_comb begin
      wb_digits = ovf_work_q ? {NUM_DIGITS{BLANK_MAX_DIGIT}} : step_next[BIN_W +: OUT_W];
      wb_nd     = ND_W'(1);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (wb_digits[i*DIGIT_W +: DIGIT_W] != '0) begin
            wb_nd = ND_W'(i + 1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      ovf_work_d = ovf_work_q;
      digits_d   = digits_q;
      nd_d       = nd_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d    = CONVERT;
               cnt_d      = '0;
               sr_d       = {{BCD_W{1'b0}}, i_value};
               ovf_work_d = 32'(i_value) > MAX_VAL;
            end
         end
         CONVERT: begin
            sr_d  = step_next;
            cnt_d = cnt_q + CNT_W'(1);
            // Final step: publish straight from the combinational step result.
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d  = IDLE;
               digits_d = wb_digits;
               nd_d     = wb_nd;
               ovf_d    = ovf_work_q;
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         ovf_work_q <= 1'b0;
         digits_q   <= '0;
         nd_q       <= ND_W'(1);
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         ovf_work_q <= ovf_work_d;
         digits_q   <= digits_d;
         nd_q       <= nd_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign o_busy       = (state_q == CONVERT);
   assign o_done       = done_q;
   assign o_digits     = digits_q;
   assign o_num_digits = nd_q;
   assign o_ovf        = ovf_q;

endmodule
